// File: rtl/water_valve_sequencer.sv
// Shut-off valve sequencer: trips on sustained flow while Wi-Fi is down, confirms the valve move, latches alarm/fault.
// Optional build macro WATER_SEQ_AUTOREARM_EN enables automatic re-arm after REARM_DELAY quiet cycles in LOCKED.
module water_valve_sequencer #(
  parameter int FLOW_LIMIT   = 4,
  parameter int MOVE_TIMEOUT = 8,
  parameter int REARM_DELAY  = 16,
  parameter int TRIP_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wifi_ok,
  input  logic              flow_detect,
  input  logic              rearm,
  input  logic              valve_closed,
  output logic              valve_close,
  output logic              alarm,
  output logic              fault,
  output logic [2:0]        state,
  output logic [TRIP_W-1:0] trip_count
);

  localparam int FW = $clog2(FLOW_LIMIT + 1);
  localparam int MW = $clog2(MOVE_TIMEOUT + 1);
  localparam logic [FW-1:0] FLOW_LAST = FW'(FLOW_LIMIT - 1);
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_TIMEOUT - 1);

  if (FLOW_LIMIT < 1 || MOVE_TIMEOUT < 1 || REARM_DELAY < 1 || TRIP_W < 1) begin : g_bad_param
    $error("water_valve_sequencer: parameters must all be >= 1");
  end

  typedef enum logic [2:0] {
    MONITOR = 3'd0,
    CLOSING = 3'd1,
    LOCKED  = 3'd2,
    OPENING = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     flow_q, flow_d;
  logic [MW-1:0]     move_q, move_d;
  logic [TRIP_W-1:0] trip_q, trip_d;
  logic              go_open;

`ifdef WATER_SEQ_AUTOREARM_EN
  localparam int RW = $clog2(REARM_DELAY + 1);
  localparam logic [RW-1:0] REARM_LAST = RW'(REARM_DELAY - 1);
  logic [RW-1:0] rearm_q, rearm_d;
`endif

  always_comb begin
    state_d = state_q;
    flow_d  = flow_q;
    move_d  = move_q;
    trip_d  = trip_q;
    go_open = 1'b0;
`ifdef WATER_SEQ_AUTOREARM_EN
    rearm_d = rearm_q;
`endif
    case (state_q)
      MONITOR: begin
        if (flow_detect && !wifi_ok) begin
          if (flow_q == FLOW_LAST) begin
            state_d = CLOSING;
            flow_d  = '0;
            move_d  = '0;
          end else begin
            flow_d = flow_q + 1'b1;
          end
        end else begin
          flow_d = '0;
        end
      end
      CLOSING: begin
        // Limit switch beats the timeout when both land on the same cycle.
        if (valve_closed) begin
          state_d = LOCKED;
          move_d  = '0;
          if (trip_q != '1) trip_d = trip_q + 1'b1;
        end else if (move_q == MOVE_LAST) begin
          state_d = FAULT;
          move_d  = '0;
        end else begin
          move_d = move_q + 1'b1;
        end
      end
      LOCKED: begin
        go_open = rearm && wifi_ok && !flow_detect;
`ifdef WATER_SEQ_AUTOREARM_EN
        if (wifi_ok && !flow_detect) begin
          if (rearm_q == REARM_LAST) go_open = 1'b1;
          else rearm_d = rearm_q + 1'b1;
        end else begin
          rearm_d = '0;
        end
        if (go_open) rearm_d = '0;
`endif
        if (go_open) begin
          state_d = OPENING;
          move_d  = '0;
        end
      end
      OPENING: begin
        if (!valve_closed) begin
          state_d = MONITOR;
          move_d  = '0;
        end else if (move_q == MOVE_LAST) begin
          state_d = FAULT;
          move_d  = '0;
        end else begin
          move_d = move_q + 1'b1;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MONITOR;
      flow_q      <= '0;
      move_q      <= '0;
      trip_q      <= '0;
      valve_close <= 1'b0;
      alarm       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flow_q      <= flow_d;
      move_q      <= move_d;
      trip_q      <= trip_d;
      // Decoded from the next state so they switch on the same edge as state.
      valve_close <= (state_d == CLOSING) || (state_d == LOCKED) || (state_d == FAULT);
      alarm       <= (state_d != MONITOR);
      fault       <= (state_d == FAULT);
    end
  end

`ifdef WATER_SEQ_AUTOREARM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rearm_q <= '0;
    else       rearm_q <= rearm_d;
  end
`endif

  assign state      = state_q;
  assign trip_count = trip_q;

endmodule

// File: tb/tb_water_valve_sequencer.sv
// Directed bench for water_valve_sequencer: rule-level model compared every cycle plus literal checkpoints.
// Honours WATER_SEQ_AUTOREARM_EN the same way as the design.
module tb_water_valve_sequencer;

  localparam int FLOW_LIMIT   = 4;
  localparam int MOVE_TIMEOUT = 8;
  localparam int REARM_DELAY  = 16;
  localparam int TRIP_W       = 8;
  localparam int TRIP_MAX     = (1 << TRIP_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wifi_ok = 1'b1;
  logic              flow_detect = 1'b0;
  logic              rearm = 1'b0;
  logic              valve_closed = 1'b0;
  logic              valve_close;
  logic              alarm;
  logic              fault;
  logic [2:0]        state;
  logic [TRIP_W-1:0] trip_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit done = 1'b0;

  water_valve_sequencer #(
    .FLOW_LIMIT(FLOW_LIMIT), .MOVE_TIMEOUT(MOVE_TIMEOUT),
    .REARM_DELAY(REARM_DELAY), .TRIP_W(TRIP_W)
  ) dut (
    .clk(clk), .reset(reset), .wifi_ok(wifi_ok), .flow_detect(flow_detect),
    .rearm(rearm), .valve_closed(valve_closed), .valve_close(valve_close),
    .alarm(alarm), .fault(fault), .state(state), .trip_count(trip_count)
  );

  // Clock / reset block
  initial forever #5 clk = ~clk;

  // Behavioural model: phase number is the architectural state code, the rest are plain tallies.
  int m_phase = 0;
  int m_run   = 0;
  int m_wait  = 0;
  int m_trips = 0;
  int m_quiet = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_run = 0; m_wait = 0; m_trips = 0; m_quiet = 0;
    end else begin
      case (m_phase)
        0: begin
          m_run = (flow_detect && !wifi_ok) ? m_run + 1 : 0;
          if (m_run == FLOW_LIMIT) begin m_phase = 1; m_run = 0; m_wait = 0; end
        end
        1: begin
          m_wait++;
          if (valve_closed) begin
            m_phase = 2; m_quiet = 0;
            m_trips = (m_trips < TRIP_MAX) ? m_trips + 1 : TRIP_MAX;
          end else if (m_wait == MOVE_TIMEOUT) m_phase = 4;
        end
        2: begin
          m_quiet = (wifi_ok && !flow_detect) ? m_quiet + 1 : 0;
          if (rearm && wifi_ok && !flow_detect) begin m_phase = 3; m_wait = 0; end
`ifdef WATER_SEQ_AUTOREARM_EN
          else if (m_quiet == REARM_DELAY) begin m_phase = 3; m_wait = 0; end
`endif
        end
        3: begin
          m_wait++;
          if (!valve_closed) m_phase = 0;
          else if (m_wait == MOVE_TIMEOUT) m_phase = 4;
        end
        default: m_phase = 4;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_cmp++;
    if (actual !== required) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // Scoreboard compare, one sample per cycle on the falling edge.
  always @(negedge clk) begin
    if (!done) begin
      logic [31:0] e_state, e_vc, e_al, e_fa, e_tc;
      e_state = reset ? 0 : m_phase;
      e_tc    = reset ? 0 : m_trips;
      e_vc    = (e_state == 1 || e_state == 2 || e_state == 4) ? 1 : 0;
      e_al    = (e_state != 0) ? 1 : 0;
      e_fa    = (e_state == 4) ? 1 : 0;
      check("cyc_state", 32'(state), e_state);
      check("cyc_valve_close", 32'(valve_close), e_vc);
      check("cyc_alarm", 32'(alarm), e_al);
      check("cyc_fault", 32'(fault), e_fa);
      check("cyc_trip_count", 32'(trip_count), e_tc);
    end
  end

  // Driver tasks: inputs change 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic qualify_trip();
    wifi_ok = 1'b0; flow_detect = 1'b1; valve_closed = 1'b0;
    repeat (FLOW_LIMIT) tick();
    wifi_ok = 1'b1; flow_detect = 1'b0;
  endtask

  task automatic close_after(input int n);
    valve_closed = 1'b0;
    repeat (n - 1) tick();
    valve_closed = 1'b1;
    tick();
  endtask

  task automatic manual_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0; valve_closed = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_valve_close", 32'(valve_close), 0);
    check("rst_alarm", 32'(alarm), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_trip_count", 32'(trip_count), 0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1;
    pulse_reset();

    // Broken burst of 3 then a full burst of 4
    wifi_ok = 1'b0; flow_detect = 1'b1;
    repeat (3) tick();
    check("t1_no_trip_burst1", 32'(state), 0);
    flow_detect = 1'b0; tick();
    flow_detect = 1'b1;
    repeat (3) tick();
    check("t1_no_trip_3of4", 32'(state), 0);
    tick();
    check("t1_trip_state", 32'(state), 1);
    check("t1_trip_valve_close", 32'(valve_close), 1);
    wifi_ok = 1'b1; flow_detect = 1'b0;

    // Close confirmed, ignored and accepted re-arms, release
    close_after(3);
    check("t2_locked", 32'(state), 2);
    check("t2_alarm", 32'(alarm), 1);
    check("t2_trips", 32'(trip_count), 1);
    wifi_ok = 1'b0; rearm = 1'b1; tick(); rearm = 1'b0; wifi_ok = 1'b1;
    check("t2_rearm_wifi_down", 32'(state), 2);
    flow_detect = 1'b1; rearm = 1'b1; tick(); rearm = 1'b0; flow_detect = 1'b0;
    check("t2_rearm_flow", 32'(state), 2);
    rearm = 1'b1; tick(); rearm = 1'b0;
    check("t2_opening", 32'(state), 3);
    check("t2_open_drive", 32'(valve_close), 0);
    check("t2_open_alarm", 32'(alarm), 1);
    valve_closed = 1'b0; tick();
    check("t2_monitor", 32'(state), 0);
    check("t2_alarm_clear", 32'(alarm), 0);

    // Switch arriving on the timeout cycle wins, both directions
    qualify_trip();
    close_after(MOVE_TIMEOUT);
    check("b_close_on_timeout", 32'(state), 2);
    rearm = 1'b1; tick(); rearm = 1'b0;
    repeat (MOVE_TIMEOUT - 1) tick();
    check("b_still_opening", 32'(state), 3);
    valve_closed = 1'b0; tick();
    check("b_release_on_timeout", 32'(state), 0);

    // Close timeout -> fault, latched until reset
    qualify_trip();
    repeat (MOVE_TIMEOUT - 1) tick();
    check("t3_before_timeout", 32'(state), 1);
    tick();
    check("t3_fault_state", 32'(state), 4);
    check("t3_fault", 32'(fault), 1);
    check("t3_fault_drive", 32'(valve_close), 1);
    rearm = 1'b1; tick(); rearm = 1'b0; tick();
    check("t3_rearm_ignored", 32'(state), 4);
    pulse_reset();

    // Reset mid-close clears the trip count
    qualify_trip();
    close_after(1);
    manual_rearm();
    check("t4_trips", 32'(trip_count), 1);
    qualify_trip();
    tick(); tick();
    check("t4_mid_close", 32'(state), 1);
    pulse_reset();

    // Saturating trip counter
    for (int i = 0; i < TRIP_MAX + 1; i++) begin
      qualify_trip();
      close_after(1);
      manual_rearm();
    end
    check("t5_saturated", 32'(trip_count), TRIP_MAX);

    // Quiet-period re-arm with a flow glitch on the tenth locked cycle
    qualify_trip();
    close_after(1);
    repeat (9) tick();
    flow_detect = 1'b1; tick(); flow_detect = 1'b0;
    repeat (REARM_DELAY - 1) tick();
    check("t6_before_delay", 32'(state), 2);
    tick();
`ifdef WATER_SEQ_AUTOREARM_EN
    check("t6_auto_open", 32'(state), 3);
`else
    check("t6_stays_locked", 32'(state), 2);
`endif
    valve_closed = 1'b0;
    tick(); tick();

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
